it_prog_loader: RTL and testbench
=================================

// Module: it_prog_loader
// PURPOSE
//  Host-side counterpart of the accumulator CPU. It writes a program image into
//  the CPU's 32x8 program memory through the programEn/Addrload/PRload/AddrSel/Input
//  port, then releases the CPU to run. During the run it supplies operands through
//  the Enter handshake, and it captures the CPU's Output when Halt asserts.
//  It sits between a host byte-stream source and the CPU top level.
// PARAMETERS
//  ADDR_W        5   program memory address width (depth = 2**ADDR_W)
//  DATA_W        8   data/instruction width
//  ENTER_CYCLES  2   cycles Enter is held high per operand (>=1)
// PORTS
//  Clock        in   1       single clock, rising edge
//  Reset        in   1       asynchronous, active-low
//  start        in   1       1-cycle pulse; begins a load (honoured in IDLE/DONE/ERR only)
//  prog_valid   in   1       program byte valid
//  prog_data    in   DATA_W  program byte
//  prog_last    in   1       marks final program byte
//  prog_ready   out  1       loader accepts program byte
//  in_valid     in   1       operand valid (RUN phase)
//  in_data      in   DATA_W  operand byte
//  in_ready     out  1       loader accepts operand
//  Halt         in   1       CPU halted
//  cpu_out      in   DATA_W  CPU Output bus
//  programEn    out  1       1 = CPU in program mode (held, not running)
//  Addrload     out  1       1-cycle pulse: CPU latches AddrSel
//  PRload       out  1       1-cycle pulse: CPU writes Input to latched address
//  AddrSel      out  ADDR_W  program memory address
//  Input        out  DATA_W  data to CPU (program byte or operand)
//  Enter        out  1       operand strobe to CPU
//  result       out  DATA_W  cpu_out captured at Halt
//  result_valid out  1       result holds a captured value
//  busy         out  1       state is not IDLE/DONE/ERR
//  err          out  1       image overflow (byte at last address without prog_last)
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE; programEn=1; all other outputs 0; addr=0.
//  States: IDLE, ACCEPT, ADDR, WRITE, RUN, ENTER, GAP, DONE, ERR.
//  IDLE/DONE/ERR: programEn=1. On start -> ACCEPT, addr=0, result_valid=0, err=0.
//  ACCEPT: prog_ready=1. On prog_valid: latch byte and last flag -> ADDR.
//  ADDR: AddrSel=addr, Addrload=1 for one cycle -> WRITE.
//  WRITE: Input=byte, PRload=1 for one cycle, AddrSel held. Then:
//   last=1 -> RUN; last=0 and addr==2**ADDR_W-1 -> ERR (err=1); otherwise addr++ -> ACCEPT.
//  Each byte takes 3 cycles from handshake to PRload; there is at most one write per 3 cycles.
//  RUN: programEn=0; in_ready=1. On in_valid: Input=in_data (held) -> ENTER.
//  ENTER: Enter=1 for exactly ENTER_CYCLES cycles with Input stable -> GAP.
//  GAP: Enter=0 for one cycle, in_ready=0 -> RUN.
//  Halt is sampled in RUN/ENTER/GAP with priority over the operand handshake:
//   result<=cpu_out, result_valid=1, Enter=0, programEn=1 -> DONE.
//   In RUN, Halt and in_valid in the same cycle: the operand is not accepted (in_ready forced 0).
//  start outside IDLE/DONE/ERR is ignored. Halt outside RUN/ENTER/GAP is ignored.
//  Reset mid-load or mid-run: immediate return to IDLE. A partial image is not restored.
//  Addrload, PRload and Enter are never high in the same cycle.
//  Addrload and PRload are only high while programEn=1.
// STRUCTURE
//  Shared package it_pkg: state enum, IT_ADDR_W=5, IT_DATA_W=8, IT_MEM_DEPTH=32.
//  Single module with an FSM and an address counter. The ENTER pulse counter is inline;
//  no sub-module.
// TESTING
//  1 Reset low mid-ENTER -> next cycle Enter=0, programEn=1, busy=0, state IDLE.
//  2 start, then bytes A0,B1,C2 (last on C2) -> Addrload/PRload pairs at AddrSel 0,1,2 with
//    Input A0,B1,C2. programEn falls the cycle after the 3rd PRload.
//  3 In RUN, in_valid with in_data=5A -> Enter high 2 cycles with Input=5A, then 1 gap cycle,
//    then in_ready=1 again.
//  4 Halt with cpu_out=3C -> result=3C, result_valid=1, programEn=1, DONE. A second start
//    clears result_valid.
//  5 Stream 33 bytes, none with prog_last -> 32 PRloads, then err=1 and ERR.
//    prog_ready=0 afterwards.
//  6 Halt and in_valid in the same RUN cycle -> no Enter pulse, in_ready=0, DONE.
//    Random valid stalls during load -> no address skipped or duplicated.

Source files
------------

// File: rtl/it_pkg.sv
// Shared types and sizes for the program loader that feeds the accumulator CPU.
// Loader states plus memory geometry of the CPU program store.
package it_pkg;

  localparam int IT_ADDR_W    = 5;
  localparam int IT_DATA_W    = 8;
  localparam int IT_MEM_DEPTH = 32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACCEPT,
    S_ADDR,
    S_WRITE,
    S_RUN,
    S_ENTER,
    S_GAP,
    S_DONE,
    S_ERR
  } it_state_e;

endpackage

// File: rtl/it_prog_loader.sv
// Host-side loader: writes a program image into the CPU, feeds operands
// through the Enter strobe and captures the CPU output at Halt.
module it_prog_loader
  import it_pkg::*;
#(
  parameter int ADDR_W       = IT_ADDR_W,
  parameter int DATA_W       = IT_DATA_W,
  parameter int ENTER_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              Halt,
  input  logic [DATA_W-1:0] cpu_out,
  output logic              programEn,
  output logic              Addrload,
  output logic              PRload,
  output logic [ADDR_W-1:0] AddrSel,
  output logic [DATA_W-1:0] Input,
  output logic              Enter,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(ENTER_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(ENTER_CYCLES - 1);

  it_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic              running;
  logic              parked;

  assign running = (state_q == S_RUN) || (state_q == S_ENTER) ||
                   (state_q == S_GAP);
  assign parked  = (state_q == S_IDLE) || (state_q == S_DONE) ||
                   (state_q == S_ERR);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rv_d    = rv_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = '0;
          rv_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (prog_valid) begin
          data_d  = prog_data;
          last_d  = prog_last;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_WRITE;
      S_WRITE: begin
        if (last_q) begin
          state_d = S_RUN;
        end else if (addr_q == ADDR_MAX) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_ACCEPT;
        end
      end
      S_RUN: begin
        if (!Halt && in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = S_ENTER;
        end
      end
      S_ENTER: begin
        if (cnt_q == CNT_LAST) state_d = S_GAP;
        else cnt_d = cnt_q + 1'b1;
      end
      S_GAP: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    // Halt wins over any operand activity while the CPU runs
    if (running && Halt) begin
      res_d   = cpu_out;
      rv_d    = 1'b1;
      state_d = S_DONE;
    end
  end

  assign prog_ready   = (state_q == S_ACCEPT);
  assign in_ready     = (state_q == S_RUN) && !Halt;
  assign Addrload     = (state_q == S_ADDR);
  assign PRload       = (state_q == S_WRITE);
  assign Enter        = (state_q == S_ENTER) && !Halt;
  assign programEn    = !running;
  assign busy         = !parked;
  assign AddrSel      = addr_q;
  assign Input        = data_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_it_prog_loader.sv
// Directed bench for it_prog_loader: load, operand entry, halt capture,
// overflow, halt/operand collision, stalled loads and async reset.
module tb_it_prog_loader;

  logic       Clock, Reset, start;
  logic       prog_valid, prog_last, prog_ready;
  logic [7:0] prog_data;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       Halt;
  logic [7:0] cpu_out;
  logic       programEn, Addrload, PRload, Enter;
  logic [4:0] AddrSel;
  logic [7:0] Input, result;
  logic       result_valid, busy, err;

  int tests = 0;
  int fails = 0;
  int al_cnt = 0;
  int viol = 0;
  logic [12:0] pq[$];
  logic [7:0]  img[$];

  it_prog_loader dut (
    .Clock(Clock), .Reset(Reset), .start(start),
    .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .Halt(Halt), .cpu_out(cpu_out), .programEn(programEn),
    .Addrload(Addrload), .PRload(PRload), .AddrSel(AddrSel),
    .Input(Input), .Enter(Enter), .result(result),
    .result_valid(result_valid), .busy(busy), .err(err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(negedge Clock) begin
    if (Reset) begin
      if (PRload) pq.push_back({AddrSel, Input});
      if (Addrload) al_cnt++;
      if ((int'(Addrload) + int'(PRload) + int'(Enter)) > 1) viol++;
      if ((Addrload || PRload) && !programEn) viol++;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) step();
    Reset = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Leaves the DUT in ADDR for the final byte
  task automatic load_img(input bit stall);
    int n;
    pulse_start();
    for (int i = 0; i < img.size(); i++) begin
      if (stall) repeat ($urandom_range(0, 2)) step();
      prog_valid = 1'b1;
      prog_data  = img[i];
      prog_last  = (i == img.size() - 1);
      n = 0;
      while (!prog_ready && n < 20) begin
        step();
        n++;
      end
      if (!prog_ready) begin
        tests++;
        fails++;
        $display("FAIL load_timeout byte=%0d", i);
      end
      step();
      prog_valid = 1'b0;
      prog_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (programEn !== 1'b1 || busy !== 1'b0 || prog_ready !== 1'b0 ||
        in_ready !== 1'b0 || Addrload !== 1'b0 || PRload !== 1'b0 ||
        Enter !== 1'b0 || AddrSel !== 5'd0 || Input !== 8'd0 ||
        result !== 8'd0 || result_valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got pe=%b busy=%b pr=%b en=%b err=%b rv=%b",
               programEn, busy, prog_ready, Enter, err, result_valid);
    end
  endtask

  task automatic test_load();
    pq.delete();
    al_cnt = 0;
    img = '{8'hA0, 8'hB1, 8'hC2};
    load_img(1'b0);
    tests++;
    if (Addrload !== 1'b1 || AddrSel !== 5'd2) begin
      fails++;
      $display("FAIL load_addr3 got al=%b a=%0d exp al=1 a=2", Addrload, AddrSel);
    end
    step();
    tests++;
    if (PRload !== 1'b1 || Input !== 8'hC2 || programEn !== 1'b1) begin
      fails++;
      $display("FAIL load_wr3 got pr=%b in=%h pe=%b exp 1 c2 1", PRload, Input, programEn);
    end
    step();
    tests++;
    if (programEn !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_run got pe=%b ir=%b exp pe=0 ir=1", programEn, in_ready);
    end
    tests++;
    if (pq.size() != 3 || al_cnt != 3) begin
      fails++;
      $display("FAIL load_count got wr=%0d al=%0d exp 3 3", pq.size(), al_cnt);
    end else if (pq[0] !== {5'd0, 8'hA0} || pq[1] !== {5'd1, 8'hB1} ||
                 pq[2] !== {5'd2, 8'hC2}) begin
      fails++;
      $display("FAIL load_pairs got %h %h %h exp 00a0 01b1 02c2", pq[0], pq[1], pq[2]);
    end
  endtask

  task automatic test_enter();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
    tests++;
    if (Enter !== 1'b1 || Input !== 8'h5A || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL enter_c1 got en=%b in=%h ir=%b exp 1 5a 0", Enter, Input, in_ready);
    end
    step();
    tests++;
    if (Enter !== 1'b1 || Input !== 8'h5A) begin
      fails++;
      $display("FAIL enter_c2 got en=%b in=%h exp 1 5a", Enter, Input);
    end
    step();
    tests++;
    if (Enter !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL enter_gap got en=%b ir=%b exp 0 0", Enter, in_ready);
    end
    step();
    tests++;
    if (in_ready !== 1'b1 || Enter !== 1'b0) begin
      fails++;
      $display("FAIL enter_back got ir=%b en=%b exp 1 0", in_ready, Enter);
    end
  endtask

  task automatic test_halt();
    Halt    = 1'b1;
    cpu_out = 8'h3C;
    step();
    Halt    = 1'b0;
    cpu_out = 8'h00;
    tests++;
    if (result !== 8'h3C || result_valid !== 1'b1 || programEn !== 1'b1 ||
        busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL halt_cap got r=%h rv=%b pe=%b busy=%b exp 3c 1 1 0",
               result, result_valid, programEn, busy);
    end
    pulse_start();
    tests++;
    if (result_valid !== 1'b0 || prog_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL halt_restart got rv=%b pr=%b exp 0 1", result_valid, prog_ready);
    end
    do_reset();
  endtask

  task automatic test_overflow();
    int acc = 0;
    int bad = 0;
    int n;
    pq.delete();
    pulse_start();
    for (int i = 0; i < 33; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'(i + 8'h10);
      n = 0;
      while (!prog_ready && n < 10) begin
        step();
        n++;
      end
      if (!prog_ready) break;
      step();
      acc++;
    end
    prog_valid = 1'b0;
    for (int i = 0; i < pq.size(); i++)
      if (pq[i] !== {5'(i), 8'(i + 8'h10)}) bad++;
    tests++;
    if (acc != 32 || pq.size() != 32 || bad != 0) begin
      fails++;
      $display("FAIL ovf_writes got acc=%0d wr=%0d bad=%0d exp 32 32 0", acc, pq.size(), bad);
    end
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || prog_ready !== 1'b0 || programEn !== 1'b1) begin
      fails++;
      $display("FAIL ovf_err got err=%b busy=%b pr=%b exp 1 0 0", err, busy, prog_ready);
    end
    prog_valid = 1'b1;
    step();
    step();
    prog_valid = 1'b0;
    tests++;
    if (prog_ready !== 1'b0 || err !== 1'b1 || PRload !== 1'b0) begin
      fails++;
      $display("FAIL ovf_hold got pr=%b err=%b exp 0 1", prog_ready, err);
    end
  endtask

  task automatic test_collide();
    do_reset();
    img = '{8'h11};
    load_img(1'b0);
    step();
    step();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    Halt     = 1'b1;
    cpu_out  = 8'h7E;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL coll_ready got ir=%b exp 0", in_ready);
    end
    step();
    in_valid = 1'b0;
    Halt     = 1'b0;
    tests++;
    if (Enter !== 1'b0 || busy !== 1'b0 || result !== 8'h7E ||
        result_valid !== 1'b1 || programEn !== 1'b1 || Input !== 8'h11) begin
      fails++;
      $display("FAIL coll_done got en=%b busy=%b r=%h in=%h exp 0 0 7e 11",
               Enter, busy, result, Input);
    end
    step();
    tests++;
    if (Enter !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL coll_after got en=%b busy=%b exp 0 0", Enter, busy);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    pq.delete();
    al_cnt = 0;
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'(8'h40 + i * 3));
    load_img(1'b1);
    step();
    step();
    for (int i = 0; i < pq.size(); i++)
      if (pq[i] !== {5'(i), 8'(8'h40 + i * 3)}) bad++;
    tests++;
    if (pq.size() != 8 || al_cnt != 8 || bad != 0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_load got wr=%0d al=%0d bad=%0d ir=%b exp 8 8 0 1",
               pq.size(), al_cnt, bad, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 8'h99;
    step();
    in_valid = 1'b0;
    tests++;
    if (Enter !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre got en=%b exp 1", Enter);
    end
    #2 Reset = 1'b0;
    step();
    tests++;
    if (Enter !== 1'b0 || programEn !== 1'b1 || busy !== 1'b0 ||
        AddrSel !== 5'd0 || Input !== 8'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rmid_idle got en=%b pe=%b busy=%b a=%0d exp 0 1 0 0",
               Enter, programEn, busy, AddrSel);
    end
    Reset = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0 || Enter !== 1'b0 || prog_ready !== 1'b0) begin
      fails++;
      $display("FAIL rmid_release got busy=%b en=%b exp 0 0", busy, Enter);
    end
  endtask

  initial begin
    Reset = 1'b0;
    start = 1'b0;
    prog_valid = 1'b0;
    prog_data = 8'h00;
    prog_last = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    Halt = 1'b0;
    cpu_out = 8'h00;
    test_reset();
    test_load();
    test_enter();
    test_halt();
    test_overflow();
    test_collide();
    test_stall();
    test_reset_mid();
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL strobe_rules got violations=%0d exp 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
